// File: rtl/dcache_ctrl.sv
// dcache_ctrl: two-way set-associative write-back data cache with a miss FSM.
// Hits return data in the same cycle. Misses stall the pipeline while a dirty
// victim is written back and the line is refilled from next-level memory.
// Optional feature: define DCACHE_STAT_EN to build saturating hit/miss counters.
module dcache_ctrl #(
   parameter int unsigned IDX_W = 8,
   parameter int unsigned TAG_W = 20
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          req,
   input  logic [31:0]   addr,
   input  logic          rw,
   input  logic [31:0]   wr_data,
   output logic [31:0]   read_data_m,
   output logic          hitway,
   output logic [127:0]  data0_rd,
   output logic [127:0]  data1_rd,
   output logic          miss_stall,
   output logic          mem_rd_req,
   output logic          mem_wr_req,
   output logic [31:0]   mem_addr,
   output logic [127:0]  mem_wr_line,
   input  logic [127:0]  mem_rd_line,
   input  logic          mem_ready,
   output logic [31:0]   hit_cnt,
   output logic [31:0]   miss_cnt
);

   localparam int unsigned SETS = 1 << IDX_W;
   localparam logic RW_WRITE = 1'b1;

   typedef enum logic [1:0] {IDLE, WRITE_BACK, ALLOCATE} state_t;

   state_t state_q, state_d;

   logic [TAG_W-1:0] tag_q   [SETS][2];
   logic [127:0]     data_q  [SETS][2];
   logic [1:0]       valid_q [SETS];
   logic [1:0]       dirty_q [SETS];
   logic [SETS-1:0]  lru_q;
   logic             victim_q;

   logic [IDX_W-1:0] idx;
   logic [TAG_W-1:0] tag;
   logic [1:0]       word;
   logic [6:0]       wbit;
   logic             hit0, hit1, hit_any, hit_way;
   logic             victim_d;
   logic [127:0]     line0, line1;
   logic             unused_addr_bits;

   assign idx  = addr[IDX_W+3:4];
   assign tag  = addr[31:32-TAG_W];
   assign word = addr[3:2];
   assign wbit = {word, 5'd0};
   assign unused_addr_bits = ^addr[1:0];

   assign line0   = data_q[idx][0];
   assign line1   = data_q[idx][1];
   assign hit0    = valid_q[idx][0] && (tag_q[idx][0] == tag);
   assign hit1    = valid_q[idx][1] && (tag_q[idx][1] == tag);
   assign hit_any = req && (hit0 || hit1);
   assign hit_way = hit1;

   // Victim: first invalid way (way0 first), otherwise the least recently used way
   assign victim_d = !valid_q[idx][0] ? 1'b0 :
                     !valid_q[idx][1] ? 1'b1 : lru_q[idx];

   function automatic logic [127:0] rot_line(input logic [127:0] l, input logic [1:0] w);
      case (w)
         2'd0:    return l;
         2'd1:    return {l[31:0], l[127:32]};
         2'd2:    return {l[63:0], l[127:64]};
         default: return {l[95:0], l[127:96]};
      endcase
   endfunction

   assign data0_rd    = rot_line(line0, word);
   assign data1_rd    = rot_line(line1, word);
   assign hitway      = hit_any ? hit_way : 1'b0;
   assign read_data_m = !hit_any ? '0 : (hit_way ? data1_rd[31:0] : data0_rd[31:0]);

   // State register; the victim way is captured on the IDLE miss transition
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         victim_q <= 1'b0;
      end else begin
         state_q <= state_d;
         if (state_q == IDLE && req && !hit_any)
            victim_q <= victim_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:
            if (req && !hit_any)
               state_d = (valid_q[idx][victim_d] && dirty_q[idx][victim_d]) ? WRITE_BACK : ALLOCATE;
         WRITE_BACK:
            if (mem_ready) state_d = ALLOCATE;
         ALLOCATE:
            if (mem_ready) state_d = IDLE;
         default:
            state_d = IDLE;
      endcase
   end

   // Output decode: stall and next-level memory requests
   always_comb begin
      miss_stall  = 1'b0;
      mem_rd_req  = 1'b0;
      mem_wr_req  = 1'b0;
      mem_addr    = '0;
      mem_wr_line = '0;
      case (state_q)
         IDLE:
            miss_stall = req && !hit_any;
         WRITE_BACK: begin
            miss_stall  = 1'b1;
            mem_wr_req  = 1'b1;
            mem_addr    = {tag_q[idx][victim_q], idx, 4'h0};
            mem_wr_line = data_q[idx][victim_q];
         end
         ALLOCATE: begin
            miss_stall = 1'b1;
            mem_rd_req = 1'b1;
            mem_addr   = {addr[31:4], 4'h0};
         end
         default: ;
      endcase
   end

   // Line metadata: valid/dirty/lru, cleared by reset
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int unsigned s = 0; s < SETS; s++) begin
            valid_q[s] <= '0;
            dirty_q[s] <= '0;
         end
         lru_q <= '0;
      end else begin
         if (state_q == IDLE && hit_any) begin
            lru_q[idx] <= ~hit_way;
            if (rw == RW_WRITE)
               dirty_q[idx][hit_way] <= 1'b1;
         end
         if (state_q == ALLOCATE && mem_ready) begin
            valid_q[idx][victim_q] <= 1'b1;
            dirty_q[idx][victim_q] <= 1'b0;
         end
      end
   end

   // Tag and data arrays: store-hit word writes and refill line writes
   always_ff @(posedge clk) begin
      if (state_q == IDLE && hit_any && rw == RW_WRITE)
         data_q[idx][hit_way][wbit +: 32] <= wr_data;
      if (state_q == ALLOCATE && mem_ready) begin
         data_q[idx][victim_q] <= mem_rd_line;
         tag_q[idx][victim_q]  <= tag;
      end
   end

`ifdef DCACHE_STAT_EN
   logic [31:0] hit_cnt_q, miss_cnt_q;

   // Saturating hit/miss statistics; a miss is counted once on leaving IDLE
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else begin
         if (state_q == IDLE && hit_any && hit_cnt_q != '1)
            hit_cnt_q <= hit_cnt_q + 32'd1;
         if (state_q == IDLE && req && !hit_any && miss_cnt_q != '1)
            miss_cnt_q <= miss_cnt_q + 32'd1;
      end
   end

   assign hit_cnt  = hit_cnt_q;
   assign miss_cnt = miss_cnt_q;
`else
   assign hit_cnt  = '0;
   assign miss_cnt = '0;
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl: scoreboard bench for dcache_ctrl. A flat reference memory
// tracks the architecturally visible contents; a separate next-level memory
// answers refills and absorbs write-backs.
`timescale 1ns/1ps
module tb_dcache_ctrl;

   logic          clk = 1'b0;
   logic          reset, req, rw, mem_ready;
   logic [31:0]   addr, wr_data;
   logic [127:0]  mem_rd_line;
   logic [31:0]   read_data_m, mem_addr, hit_cnt, miss_cnt;
   logic          hitway, miss_stall, mem_rd_req, mem_wr_req;
   logic [127:0]  data0_rd, data1_rd, mem_wr_line;

   always #5 clk = ~clk;

   dcache_ctrl #(.IDX_W(8), .TAG_W(20)) dut (
      .clk(clk), .reset(reset), .req(req), .addr(addr), .rw(rw), .wr_data(wr_data),
      .read_data_m(read_data_m), .hitway(hitway), .data0_rd(data0_rd), .data1_rd(data1_rd),
      .miss_stall(miss_stall), .mem_rd_req(mem_rd_req), .mem_wr_req(mem_wr_req),
      .mem_addr(mem_addr), .mem_wr_line(mem_wr_line), .mem_rd_line(mem_rd_line),
      .mem_ready(mem_ready), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
   );

   typedef struct {
      logic [31:0]  word;
      logic [127:0] line;
   } exp_t;

   exp_t         sb[$];
   logic [127:0] mem_m [logic [31:0]];
   logic [127:0] ref_m [logic [31:0]];
   int           checks = 0;
   int           passed = 0;

   function automatic logic [127:0] mem_line(input logic [31:0] la);
      if (mem_m.exists(la)) return mem_m[la];
      return {la ^ 32'hA5A5_000C, la ^ 32'hA5A5_0008, la ^ 32'hA5A5_0004, la ^ 32'hA5A5_0000};
   endfunction

   function automatic logic [127:0] ref_line(input logic [31:0] la);
      if (ref_m.exists(la)) return ref_m[la];
      return mem_line(la);
   endfunction

   function automatic logic [127:0] rot_exp(input logic [127:0] l, input int w);
      logic [255:0] t;
      t = {l, l} >> (32 * w);
      return t[127:0];
   endfunction

   // One access; services refill/write-back requests until the access completes
   task automatic access(input logic [31:0] a, input logic w, input logic [31:0] d,
                         input int exp_miss, output int n_wr, output int n_rd,
                         output logic [31:0] first_maddr, output logic hw);
      exp_t         e;
      logic         missed, got, done;
      logic [31:0]  la;
      logic [127:0] l;
      la = {a[31:4], 4'h0};
      @(negedge clk);
      req = 1'b1; addr = a; rw = w; wr_data = d;
      e.line = rot_exp(ref_line(la), int'(a[3:2]));
      e.word = e.line[31:0];
      sb.push_back(e);
      #1;
      missed = miss_stall; n_wr = 0; n_rd = 0; first_maddr = '0; hw = 1'b0; got = 1'b0; done = 1'b0;
      if (exp_miss != 2) begin
         checks++;
         if (missed !== exp_miss[0]) $display("FAIL miss_detect @%h: got %b expected %b", a, missed, exp_miss[0]);
         else passed++;
      end
      for (int cyc = 0; cyc < 64 && !done; cyc++) begin
         checks++;
         if (mem_rd_req && mem_wr_req) $display("FAIL req_exclusive @%h: rd=%b wr=%b expected not both", a, mem_rd_req, mem_wr_req);
         else passed++;
         if (!miss_stall) begin
            e = sb.pop_front();
            checks++;
            if (read_data_m !== e.word) $display("FAIL read_data @%h: got %h expected %h", a, read_data_m, e.word);
            else passed++;
            l = hitway ? data1_rd : data0_rd;
            checks++;
            if (l !== e.line) $display("FAIL rotated_line @%h: got %h expected %h", a, l, e.line);
            else passed++;
            hw = hitway;
            done = 1'b1;
         end else begin
            if ((mem_wr_req || mem_rd_req) && !got) begin
               first_maddr = mem_addr; got = 1'b1;
            end
            if (mem_wr_req) begin
               n_wr++;
               checks++;
               if (mem_wr_line !== ref_line(mem_addr)) $display("FAIL wb_line @%h: got %h expected %h", mem_addr, mem_wr_line, ref_line(mem_addr));
               else passed++;
               mem_m[mem_addr] = mem_wr_line;
               mem_ready = 1'b1;
            end else if (mem_rd_req) begin
               n_rd++;
               mem_rd_line = mem_line(mem_addr);
               mem_ready = 1'b1;
            end
            @(negedge clk);
            mem_ready = 1'b0;
            #1;
         end
      end
      if (!done) begin
         checks++;
         $display("FAIL access_timeout @%h: got no completion expected completion within 64 cycles", a);
         if (sb.size() > 0) void'(sb.pop_front());
      end else if (w) begin
         l = ref_line(la);
         l[32*int'(a[3:2]) +: 32] = d;
         ref_m[la] = l;
      end
   endtask

   task automatic go_idle();
      @(negedge clk);
      req = 1'b0; rw = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1; req = 1'b0; mem_ready = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      ref_m.delete();
      sb.delete();
   endtask

   task automatic test_reset();
      reset = 1'b1; req = 1'b0; rw = 1'b0; addr = '0; wr_data = '0;
      mem_ready = 1'b0; mem_rd_line = '0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      checks++; if (miss_stall !== 1'b0) $display("FAIL reset_stall: got %b expected 0", miss_stall); else passed++;
      checks++; if (mem_rd_req !== 1'b0) $display("FAIL reset_rd_req: got %b expected 0", mem_rd_req); else passed++;
      checks++; if (mem_wr_req !== 1'b0) $display("FAIL reset_wr_req: got %b expected 0", mem_wr_req); else passed++;
      checks++; if (hit_cnt !== 32'h0) $display("FAIL reset_hit_cnt: got %h expected 0", hit_cnt); else passed++;
      checks++; if (miss_cnt !== 32'h0) $display("FAIL reset_miss_cnt: got %h expected 0", miss_cnt); else passed++;
   endtask

   task automatic test_first_fill();
      int nw, nr; logic [31:0] fa; logic hw;
      mem_m[32'h1000] = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
      access(32'h1000, 1'b0, '0, 1, nw, nr, fa, hw);
      checks++; if (nw !== 0) $display("FAIL fill_wr_eps: got %0d expected 0", nw); else passed++;
      checks++; if (nr !== 1) $display("FAIL fill_rd_eps: got %0d expected 1", nr); else passed++;
      checks++; if (fa !== 32'h1000) $display("FAIL fill_mem_addr: got %h expected 00001000", fa); else passed++;
      checks++; if (hw !== 1'b0) $display("FAIL fill_hitway: got %b expected 0", hw); else passed++;
      access(32'h1004, 1'b0, '0, 0, nw, nr, fa, hw);
   endtask

   task automatic test_store_hit();
      int nw, nr; logic [31:0] fa; logic hw;
      access(32'h1008, 1'b1, 32'hDEAD_BEEF, 0, nw, nr, fa, hw);
      access(32'h1008, 1'b0, '0, 0, nw, nr, fa, hw);
   endtask

   task automatic test_dirty_evict();
      int nw, nr; logic [31:0] fa; logic hw;
      access(32'h2000, 1'b0, '0, 1, nw, nr, fa, hw);
      checks++; if (hw !== 1'b1) $display("FAIL second_fill_way: got %b expected 1", hw); else passed++;
      access(32'h2000, 1'b0, '0, 0, nw, nr, fa, hw);
      access(32'h3000, 1'b0, '0, 1, nw, nr, fa, hw);
      checks++; if (nw !== 1) $display("FAIL evict_wr_eps: got %0d expected 1", nw); else passed++;
      checks++; if (nr !== 1) $display("FAIL evict_rd_eps: got %0d expected 1", nr); else passed++;
      checks++; if (fa !== 32'h1000) $display("FAIL evict_wb_addr: got %h expected 00001000", fa); else passed++;
      checks++; if (hw !== 1'b0) $display("FAIL evict_hitway: got %b expected 0", hw); else passed++;
   endtask

   task automatic test_clean_victim();
      int nw, nr; logic [31:0] fa; logic hw;
      access(32'h3004, 1'b0, '0, 0, nw, nr, fa, hw);
      access(32'h1008, 1'b0, '0, 1, nw, nr, fa, hw);
      checks++; if (nw !== 0) $display("FAIL clean_wr_eps: got %0d expected 0", nw); else passed++;
      checks++; if (nr !== 1) $display("FAIL clean_rd_eps: got %0d expected 1", nr); else passed++;
      checks++; if (fa !== 32'h1000) $display("FAIL clean_mem_addr: got %h expected 00001000", fa); else passed++;
      checks++; if (hw !== 1'b1) $display("FAIL clean_hitway: got %b expected 1", hw); else passed++;
   endtask

   task automatic test_back_to_back();
      int nw, nr; logic [31:0] fa, a; logic hw, w;
      for (int i = 0; i < 40; i++) begin
         a = (32'($urandom_range(4, 6)) << 12) | (32'($urandom_range(0, 1)) << 4) | (32'($urandom_range(0, 3)) << 2);
         w = 1'($urandom_range(0, 1));
         access(a, w, $urandom, 2, nw, nr, fa, hw);
      end
      go_idle();
   endtask

   task automatic test_reset_mid_wb();
      int nw, nr; logic [31:0] fa; logic hw; logic seen;
      do_reset();
      access(32'h1000, 1'b1, 32'h1234_5678, 1, nw, nr, fa, hw);
      access(32'h2000, 1'b0, '0, 1, nw, nr, fa, hw);
      access(32'h2000, 1'b0, '0, 0, nw, nr, fa, hw);
      @(negedge clk);
      req = 1'b1; addr = 32'h3000; rw = 1'b0;
      #1;
      seen = 1'b0;
      for (int c = 0; c < 8 && !seen; c++) begin
         if (mem_wr_req) seen = 1'b1;
         else begin @(negedge clk); #1; end
      end
      checks++;
      if (!seen) $display("FAIL wb_entry_timeout: got no mem_wr_req expected mem_wr_req within 8 cycles");
      else passed++;
      reset = 1'b1;
      #1;
      checks++; if (mem_wr_req !== 1'b0) $display("FAIL async_wr_drop: got %b expected 0", mem_wr_req); else passed++;
      checks++; if (mem_rd_req !== 1'b0) $display("FAIL async_rd_drop: got %b expected 0", mem_rd_req); else passed++;
      @(negedge clk);
      reset = 1'b0; req = 1'b0;
      ref_m.delete();
      sb.delete();
      access(32'h1000, 1'b0, '0, 1, nw, nr, fa, hw);
      checks++; if (nw !== 0) $display("FAIL post_reset_wr_eps: got %0d expected 0", nw); else passed++;
      go_idle();
   endtask

   task automatic test_stats();
      int nw, nr; logic [31:0] fa; logic hw;
      do_reset();
      @(negedge clk);
      mem_rd_line = '1; mem_ready = 1'b1;
      @(negedge clk);
      mem_ready = 1'b0;
      access(32'h1000, 1'b0, '0, 1, nw, nr, fa, hw);
      access(32'h1000, 1'b0, '0, 0, nw, nr, fa, hw);
      access(32'h2000, 1'b0, '0, 1, nw, nr, fa, hw);
      access(32'h2004, 1'b0, '0, 0, nw, nr, fa, hw);
      access(32'h3000, 1'b0, '0, 1, nw, nr, fa, hw);
      checks++; if (nw !== 0) $display("FAIL stats_clean_victim: got %0d expected 0", nw); else passed++;
      go_idle();
      @(negedge clk);
`ifdef DCACHE_STAT_EN
      checks++; if (hit_cnt !== 32'd5) $display("FAIL hit_cnt: got %0d expected 5", hit_cnt); else passed++;
      checks++; if (miss_cnt !== 32'd3) $display("FAIL miss_cnt: got %0d expected 3", miss_cnt); else passed++;
`else
      checks++; if (hit_cnt !== 32'd0) $display("FAIL hit_cnt: got %0d expected 0", hit_cnt); else passed++;
      checks++; if (miss_cnt !== 32'd0) $display("FAIL miss_cnt: got %0d expected 0", miss_cnt); else passed++;
`endif
   endtask

   initial begin
      test_reset();
      test_first_fill();
      test_store_hit();
      test_dirty_evict();
      test_clean_victim();
      test_back_to_back();
      test_reset_mid_wb();
      test_stats();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: got no finish expected finish before 2ms");
      $fatal(1, "timeout");
   end

endmodule
